// File: rtl/arb_requester.sv
// arb_requester: four independent job requesters that queue jobs, request an arbiter and run fixed-length transfers
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   job_push[3:0]     enqueue one job for port i
//   Grant[3:0]        arbiter grant, sampled only at the clock edge
//   Req[3:0]          registered request, high exactly while port i is in REQ
//   xfer_active[3:0]  port i is transferring
//   done[3:0]         one-cycle pulse on the last transfer cycle of port i
//   pending           per-port job count, port i at [i*CNT_W +: CNT_W]
//   overflow[3:0]     sticky: a push was dropped on a full port
//   starve[3:0]       sticky: port i waited TIMEOUT cycles ungranted
//   grant_err         sticky: multi-hot grant or grant to a non-requesting port
module arb_requester #(
    parameter int BEAT_LEN = 2,
    parameter int TIMEOUT  = 8,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         job_push,
    input  logic [3:0]         Grant,
    output logic [3:0]         Req,
    output logic [3:0]         xfer_active,
    output logic [3:0]         done,
    output logic [4*CNT_W-1:0] pending,
    output logic [3:0]         overflow,
    output logic [3:0]         starve,
    output logic               grant_err
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    localparam logic [CNT_W-1:0] FULL = {CNT_W{1'b1}};
    localparam logic [3:0]       LAST = 4'(BEAT_LEN - 1);
    localparam logic [7:0]       TMO  = 8'(TIMEOUT);

    state_t           r_state [4];
    state_t           w_next  [4];
    logic [CNT_W-1:0] r_pend  [4];
    logic [CNT_W-1:0] w_pend  [4];
    logic [3:0]       r_beat  [4];
    logic [7:0]       r_wait  [4];
    logic [3:0]       r_ovf;
    logic [3:0]       r_starve;
    logic             r_gerr;
    logic [3:0]       w_dec;
    logic [3:0]       w_ovf;
    logic [3:0]       w_starve;
    logic             w_gerr;

    always_comb begin
        Req         = '0;
        xfer_active = '0;
        done        = '0;
        pending     = '0;
        w_dec       = '0;
        w_ovf       = '0;
        w_starve    = '0;
        for (int i = 0; i < 4; i++) begin
            w_next[i] = r_state[i];
            w_dec[i]  = r_state[i] == XFER && r_beat[i] == LAST;
            // a push coinciding with the completing job's decrement always fits
            w_ovf[i]  = job_push[i] && !w_dec[i] && r_pend[i] == FULL;
            w_pend[i] = (job_push[i] && !w_dec[i] && !w_ovf[i]) ? r_pend[i] + CNT_W'(1) :
                        (w_dec[i] && !job_push[i]) ? r_pend[i] - CNT_W'(1) : r_pend[i];
            w_starve[i] = r_state[i] == REQ && !Grant[i] && r_wait[i] == TMO - 8'd1;
            case (r_state[i])
                IDLE:    w_next[i] = (r_pend[i] != '0) ? REQ : IDLE;
                REQ:     w_next[i] = Grant[i] ? XFER : REQ;
                XFER:    w_next[i] = w_dec[i] ? GAP : XFER;
                default: w_next[i] = (r_pend[i] != '0) ? REQ : IDLE;
            endcase
            Req[i]         = r_state[i] == REQ;
            xfer_active[i] = r_state[i] == XFER;
            done[i]        = w_dec[i];
            pending[i*CNT_W +: CNT_W] = r_pend[i];
        end
    end

    // multi-hot check: clearing the lowest set bit leaves something behind
    assign w_gerr    = ((Grant & (Grant - 4'd1)) != 4'd0) || ((Grant & ~Req) != 4'd0);
    assign overflow  = r_ovf;
    assign starve    = r_starve;
    assign grant_err = r_gerr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= IDLE;
                r_pend[i]  <= '0;
                r_beat[i]  <= '0;
                r_wait[i]  <= '0;
            end
            r_ovf    <= '0;
            r_starve <= '0;
            r_gerr   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_next[i];
                r_pend[i]  <= w_pend[i];
                r_beat[i]  <= (r_state[i] == XFER && !w_dec[i]) ? r_beat[i] + 4'd1 : 4'd0;
                // zero outside REQ, so every REQ entry starts from a cleared count
                r_wait[i]  <= (r_state[i] == REQ && !Grant[i]) ?
                              ((r_wait[i] == TMO) ? TMO : r_wait[i] + 8'd1) : 8'd0;
            end
            r_ovf    <= r_ovf | w_ovf;
            r_starve <= r_starve | w_starve;
            r_gerr   <= r_gerr | w_gerr;
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: scenario tasks with inline checks plus a done-pulse scoreboard
module tb_arb_requester;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  job_push = '0;
    logic [3:0]  Grant = '0;
    logic [3:0]  Req, xfer_active, done, overflow, starve;
    logic [11:0] pending;
    logic        grant_err;

    int total = 0;
    int bad = 0;
    int exp_done [$];
    int exp_p;

    arb_requester #(.BEAT_LEN(2), .TIMEOUT(8), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .job_push(job_push), .Grant(Grant),
        .Req(Req), .xfer_active(xfer_active), .done(done), .pending(pending),
        .overflow(overflow), .starve(starve), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // each done pulse must match the oldest granted job still outstanding
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++) begin
                if (done[p]) begin
                    total++;
                    if (exp_done.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_done: port %0d pulsed with no job granted", p);
                    end else begin
                        exp_p = exp_done.pop_front();
                        if (p !== exp_p) begin
                            bad++;
                            $display("FAIL sb_done_port: got port %0d expected port %0d", p, exp_p);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_req(input int p, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            n++;
            ok = Req[p];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        job_push = '0;
        Grant = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        job_push = 4'hF;
        Grant = 4'hF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({Req, xfer_active, done, pending, overflow, starve, grant_err} !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {Req, xfer_active, done, pending, overflow, starve, grant_err});
        end
        rst = 1'b0;
        job_push = '0;
        Grant = '0;
        @(negedge clk);
        total++;
        if ({pending, Req, grant_err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_ignores_inputs: got %h expected 0", {pending, Req, grant_err});
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        job_push = 4'b0001;
        @(negedge clk);
        job_push = '0;
        total++;
        if (pending[2:0] !== 3'd1 || Req[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_t1: pending0=%0d Req0=%b expected 1 and 0", pending[2:0], Req[0]);
        end
        @(negedge clk);
        total++;
        if (Req !== 4'b0001) begin
            bad++;
            $display("FAIL single_req_t2: Req=%b expected 0001", Req);
        end
        Grant = 4'b0001;
        exp_done.push_back(0);
        @(negedge clk);
        Grant = '0;
        total++;
        if (Req[0] !== 1'b0 || xfer_active[0] !== 1'b1 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_beat0: Req0=%b xfer0=%b done0=%b expected 0 1 0", Req[0], xfer_active[0], done[0]);
        end
        @(negedge clk);
        total++;
        if (xfer_active[0] !== 1'b1 || done[0] !== 1'b1 || pending[2:0] !== 3'd1) begin
            bad++;
            $display("FAIL single_beat1: xfer0=%b done0=%b pending0=%0d expected 1 1 1", xfer_active[0], done[0], pending[2:0]);
        end
        @(negedge clk);
        total++;
        if (xfer_active[0] !== 1'b0 || Req[0] !== 1'b0 || pending[2:0] !== 3'd0) begin
            bad++;
            $display("FAIL single_gap: xfer0=%b Req0=%b pending0=%0d expected 0 0 0", xfer_active[0], Req[0], pending[2:0]);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (Req !== 4'b0000 || xfer_active !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle: Req=%b xfer=%b expected 0000 0000", Req, xfer_active);
        end
    endtask

    task automatic test_multi();
        bit ok;
        int n;
        @(negedge clk);
        job_push = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        job_push = '0;
        total++;
        if (pending[8:6] !== 3'd3 || Req !== 4'b0100) begin
            bad++;
            $display("FAIL multi_queued: pending2=%0d Req=%b expected 3 0100", pending[8:6], Req);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_req(2, ok, n);
                total++;
                if (!ok || n != 1) begin
                    bad++;
                    $display("FAIL multi_rereq_%0d: ok=%b cycles=%0d expected 1 after one gap cycle", k, ok, n);
                end
            end
            Grant = 4'b0100;
            exp_done.push_back(2);
            @(negedge clk);
            Grant = '0;
            total++;
            if (xfer_active[2] !== 1'b1 || Req[2] !== 1'b0) begin
                bad++;
                $display("FAIL multi_xfer_%0d: xfer2=%b Req2=%b expected 1 0", k, xfer_active[2], Req[2]);
            end
            @(negedge clk);
            @(negedge clk);
            total++;
            if (Req[2] !== 1'b0 || xfer_active[2] !== 1'b0 || pending[8:6] !== 3'(2 - k)) begin
                bad++;
                $display("FAIL multi_gap_%0d: Req2=%b xfer2=%b pending2=%0d expected 0 0 %0d", k, Req[2], xfer_active[2], pending[8:6], 2 - k);
            end
        end
        @(negedge clk);
        total++;
        if (Req[2] !== 1'b0) begin
            bad++;
            $display("FAIL multi_idle: Req2=%b expected 0", Req[2]);
        end
    endtask

    task automatic test_overflow_starve();
        @(negedge clk);
        job_push = 4'b0010;
        for (int k = 0; k < 8; k++) @(negedge clk);
        job_push = '0;
        total++;
        if (pending[5:3] !== 3'd7 || overflow !== 4'b0010) begin
            bad++;
            $display("FAIL overflow: pending1=%0d overflow=%b expected 7 0010", pending[5:3], overflow);
        end
        @(negedge clk);
        total++;
        if (starve !== 4'b0000 || Req[1] !== 1'b1) begin
            bad++;
            $display("FAIL starve_early: starve=%b Req1=%b expected 0000 1", starve, Req[1]);
        end
        @(negedge clk);
        total++;
        if (starve !== 4'b0010 || Req[1] !== 1'b1 || pending[5:3] !== 3'd7) begin
            bad++;
            $display("FAIL starve_set: starve=%b Req1=%b pending1=%0d expected 0010 1 7", starve, Req[1], pending[5:3]);
        end
        do_reset();
    endtask

    task automatic test_grant_err();
        bit ok;
        int n;
        @(negedge clk);
        job_push = 4'b0001;
        @(negedge clk);
        job_push = '0;
        wait_req(0, ok, n);
        total++;
        if (!ok || grant_err !== 1'b0) begin
            bad++;
            $display("FAIL gerr_pre: Req0 seen=%b grant_err=%b expected 1 0", ok, grant_err);
        end
        Grant = 4'b0011;
        exp_done.push_back(0);
        @(negedge clk);
        Grant = '0;
        total++;
        if (grant_err !== 1'b1 || xfer_active !== 4'b0001 || Req[1] !== 1'b0 || pending[5:3] !== 3'd0) begin
            bad++;
            $display("FAIL gerr: grant_err=%b xfer=%b Req1=%b pending1=%0d expected 1 0001 0 0", grant_err, xfer_active, Req[1], pending[5:3]);
        end
        for (int k = 0; k < 4; k++) @(negedge clk);
        do_reset();
    endtask

    task automatic test_reset_mid_xfer();
        bit ok;
        int n;
        @(negedge clk);
        job_push = 4'b1000;
        @(negedge clk);
        job_push = '0;
        wait_req(3, ok, n);
        Grant = 4'b1000;
        @(negedge clk);
        Grant = '0;
        total++;
        if (!ok || xfer_active[3] !== 1'b1 || done[3] !== 1'b0) begin
            bad++;
            $display("FAIL abort_setup: Req3 seen=%b xfer3=%b done3=%b expected 1 1 0", ok, xfer_active[3], done[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({Req, xfer_active, done, pending, overflow, starve, grant_err} !== 33'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h expected 0",
                     {Req, xfer_active, done, pending, overflow, starve, grant_err});
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({Req, xfer_active, done} !== 12'd0) begin
            bad++;
            $display("FAIL abort_quiet: Req/xfer/done=%h expected 0", {Req, xfer_active, done});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        @(negedge clk);
        job_push = 4'b0001;
        @(negedge clk);
        job_push = '0;
        wait_req(0, ok, n);
        Grant = 4'b0001;
        exp_done.push_back(0);
        @(negedge clk);
        Grant = '0;
        @(negedge clk);
        total++;
        if (!ok || done[0] !== 1'b1 || pending[2:0] !== 3'd1) begin
            bad++;
            $display("FAIL b2b_last: Req0 seen=%b done0=%b pending0=%0d expected 1 1 1", ok, done[0], pending[2:0]);
        end
        job_push = 4'b0001;
        @(negedge clk);
        job_push = '0;
        total++;
        if (pending[2:0] !== 3'd1 || Req[0] !== 1'b0 || xfer_active[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: pending0=%0d Req0=%b xfer0=%b expected 1 0 0", pending[2:0], Req[0], xfer_active[0]);
        end
        @(negedge clk);
        total++;
        if (Req[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rereq: Req0=%b expected 1", Req[0]);
        end
        Grant = 4'b0001;
        exp_done.push_back(0);
        @(negedge clk);
        Grant = '0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        total++;
        if (pending[2:0] !== 3'd0 || Req[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: pending0=%0d Req0=%b expected 0 0", pending[2:0], Req[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_overflow_starve();
        test_grant_err();
        test_reset_mid_xfer();
        test_back_to_back();
        @(negedge clk);
        total++;
        if (exp_done.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d granted jobs never completed, expected 0", exp_done.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
